// File: rtl/otter_iobus_responder.sv
// OTTER IOBUS responder: switch input, LED output and a prescaled 32-bit compare timer with interrupt.
// Optional build macro OTTER_IO_RDREG_EN registers IOBUS_IN (one cycle read latency).
module otter_iobus_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h1100_0000,
    parameter int unsigned LED_W     = 16,
    parameter int unsigned SW_W      = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [31:0]      IOBUS_ADDR,
    input  logic [31:0]      IOBUS_OUT,
    input  logic             IOBUS_WR,
    output logic [31:0]      IOBUS_IN,
    input  logic [SW_W-1:0]  SWITCHES,
    output logic [LED_W-1:0] LEDS,
    output logic             INTR
);

    localparam logic [5:0] OFF_SW    = 6'h00;
    localparam logic [5:0] OFF_LED   = 6'h01;
    localparam logic [5:0] OFF_CTRL  = 6'h02;
    localparam logic [5:0] OFF_PRESC = 6'h03;
    localparam logic [5:0] OFF_CMP   = 6'h04;
    localparam logic [5:0] OFF_COUNT = 6'h05;
    localparam logic [5:0] OFF_STAT  = 6'h06;

    logic [SW_W-1:0]  sw_meta_q, sw_sync_q;
    logic [LED_W-1:0] led_q, led_d;
    logic             en_q, en_d;
    logic             auto_q, auto_d;
    logic             ie_q, ie_d;
    logic [15:0]      presc_q, presc_d;
    logic [31:0]      cmp_q, cmp_d;
    logic [31:0]      count_q, count_d;
    logic [15:0]      pre_cnt_q, pre_cnt_d;
    logic             pend_q, pend_d;
    logic [31:0]      rdata;

    logic       hit;
    logic [5:0] sel;
    logic       wr_en;
    logic       tick;
    logic       match;
    logic       unused_addr_lsbs;

    assign hit              = (IOBUS_ADDR[31:8] == BASE_ADDR[31:8]);
    assign sel              = IOBUS_ADDR[7:2];
    assign wr_en            = IOBUS_WR & hit;
    assign tick             = en_q && (pre_cnt_q == presc_q);
    assign match            = tick && (count_q == cmp_q);
    assign unused_addr_lsbs = ^IOBUS_ADDR[1:0];

    // Two-flop synchroniser for the asynchronous board switches.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_meta_q <= SWITCHES;
            sw_sync_q <= sw_meta_q;
        end
    end

    // NOTE: every signal gets its hold value first, so no path through this block infers a latch.
    always_comb begin
        led_d     = led_q;
        en_d      = en_q;
        auto_d    = auto_q;
        ie_d      = ie_q;
        presc_d   = presc_q;
        cmp_d     = cmp_q;
        count_d   = count_q;
        pre_cnt_d = pre_cnt_q;
        pend_d    = pend_q;

        if (!en_q || tick) begin
            pre_cnt_d = '0;
        end else begin
            pre_cnt_d = pre_cnt_q + 16'd1;
        end

        if (tick) begin
            if (count_q == cmp_q) begin
                if (auto_q) begin
                    count_d = '0;
                end else begin
                    en_d = 1'b0;
                end
            end else begin
                count_d = count_q + 32'd1;
            end
        end

        // Clear first so a same-cycle compare event still leaves PEND set.
        if (wr_en && sel == OFF_STAT && IOBUS_OUT[0]) begin
            pend_d = 1'b0;
        end
        if (match) begin
            pend_d = 1'b1;
        end

        if (wr_en) begin
            case (sel)
                OFF_LED:   led_d = IOBUS_OUT[LED_W-1:0];
                OFF_CTRL: begin
                    en_d   = IOBUS_OUT[0];
                    auto_d = IOBUS_OUT[1];
                    ie_d   = IOBUS_OUT[2];
                    if (!IOBUS_OUT[0]) begin
                        pre_cnt_d = '0;
                    end
                end
                OFF_PRESC: presc_d = IOBUS_OUT[15:0];
                OFF_CMP:   cmp_d   = IOBUS_OUT;
                OFF_COUNT: begin
                    count_d   = IOBUS_OUT;
                    pre_cnt_d = '0;
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            led_q     <= '0;
            en_q      <= 1'b0;
            auto_q    <= 1'b0;
            ie_q      <= 1'b0;
            presc_q   <= '0;
            cmp_q     <= '0;
            count_q   <= '0;
            pre_cnt_q <= '0;
            pend_q    <= 1'b0;
        end else begin
            led_q     <= led_d;
            en_q      <= en_d;
            auto_q    <= auto_d;
            ie_q      <= ie_d;
            presc_q   <= presc_d;
            cmp_q     <= cmp_d;
            count_q   <= count_d;
            pre_cnt_q <= pre_cnt_d;
            pend_q    <= pend_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (sel)
                OFF_SW:    rdata[SW_W-1:0]  = sw_sync_q;
                OFF_LED:   rdata[LED_W-1:0] = led_q;
                OFF_CTRL:  rdata[2:0]       = {ie_q, auto_q, en_q};
                OFF_PRESC: rdata[15:0]      = presc_q;
                OFF_CMP:   rdata            = cmp_q;
                OFF_COUNT: rdata            = count_q;
                OFF_STAT:  rdata[0]         = pend_q;
                default: ;
            endcase
        end
    end

`ifdef OTTER_IO_RDREG_EN
    logic [31:0] rdata_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata;
        end
    end

    assign IOBUS_IN = rdata_q;
`else
    assign IOBUS_IN = rdata;
`endif

    assign LEDS = led_q;
    assign INTR = pend_q & ie_q;

endmodule

// File: tb/tb_otter_iobus_responder.sv
// Directed self-checking bench for otter_iobus_responder: register access, switch sync, timer and collisions.
module tb_otter_iobus_responder;

    localparam logic [31:0] A_SW    = 32'h1100_0000;
    localparam logic [31:0] A_LED   = 32'h1100_0004;
    localparam logic [31:0] A_CTRL  = 32'h1100_0008;
    localparam logic [31:0] A_PRESC = 32'h1100_000C;
    localparam logic [31:0] A_CMP   = 32'h1100_0010;
    localparam logic [31:0] A_COUNT = 32'h1100_0014;
    localparam logic [31:0] A_STAT  = 32'h1100_0018;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] IOBUS_ADDR = '0;
    logic [31:0] IOBUS_OUT = '0;
    logic        IOBUS_WR = 1'b0;
    logic [31:0] IOBUS_IN;
    logic [15:0] SWITCHES = '0;
    logic [15:0] LEDS;
    logic        INTR;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] rv;

    otter_iobus_responder dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .IOBUS_ADDR (IOBUS_ADDR),
        .IOBUS_OUT  (IOBUS_OUT),
        .IOBUS_WR   (IOBUS_WR),
        .IOBUS_IN   (IOBUS_IN),
        .SWITCHES   (SWITCHES),
        .LEDS       (LEDS),
        .INTR       (INTR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive at a falling edge, commit on the following rising edge, return at the next falling edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge CLK);
        IOBUS_ADDR = a;
        IOBUS_OUT  = d;
        IOBUS_WR   = 1'b1;
        @(negedge CLK);
        IOBUS_WR   = 1'b0;
        IOBUS_ADDR = '0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        IOBUS_ADDR = a;
        IOBUS_WR   = 1'b0;
`ifdef OTTER_IO_RDREG_EN
        @(negedge CLK);
`endif
        #1 d = IOBUS_IN;
    endtask

    initial begin
        // Reset release, then an asynchronous reset pulse between clock edges.
        @(negedge CLK);
        RESET = 1'b0;
        wr(A_LED, 32'h0000_1234);
        check("led_pre_reset", {16'h0, LEDS}, 32'h0000_1234);
        IOBUS_ADDR = A_LED;
        #2 RESET = 1'b1;
        #1;
        check("reset_leds", {16'h0, LEDS}, 32'h0);
        check("reset_intr", {31'h0, INTR}, 32'h0);
        check("reset_iobus_in", IOBUS_IN, 32'h0);
        @(negedge CLK);
        RESET = 1'b0;
        rd(A_CTRL, rv);
        check("ctrl_after_reset", rv, 32'h0);

        // LED register, unmapped offset, non-hit address, ignored low address bits.
        wr(A_LED, 32'h0000_A5A5);
        check("leds_a5a5", {16'h0, LEDS}, 32'h0000_A5A5);
        rd(A_LED, rv);
        check("rd_led", rv, 32'h0000_A5A5);
        wr(32'h1100_0040, 32'hFFFF_FFFF);
        check("unmapped_wr_leds", {16'h0, LEDS}, 32'h0000_A5A5);
        rd(32'h1100_0040, rv);
        check("rd_unmapped", rv, 32'h0);
        rd(32'h1200_0004, rv);
        check("rd_nonhit", rv, 32'h0);
        rd(32'h1100_0007, rv);
        check("rd_led_lsbs", rv, 32'h0000_A5A5);

        // Same-cycle read returns the value before the write.
        @(negedge CLK);
        IOBUS_ADDR = A_LED;
        IOBUS_OUT  = 32'h0000_1111;
        IOBUS_WR   = 1'b1;
        #1 check("rd_before_wr", IOBUS_IN, 32'h0000_A5A5);
        @(negedge CLK);
        IOBUS_WR = 1'b0;
        check("leds_1111", {16'h0, LEDS}, 32'h0000_1111);
        wr(A_LED, 32'h0000_A5A5);

        // Switch synchroniser latency.
        @(negedge CLK);
        SWITCHES = 16'h00F0;
        rd(A_SW, rv);
        check("sw_lat0", rv, 32'h0);
        @(negedge CLK);
        rd(A_SW, rv);
        check("sw_lat1", rv, 32'h0);
        @(negedge CLK);
        rd(A_SW, rv);
        check("sw_lat2", rv, 32'h0000_00F0);

        // Auto-reload: PRESC=3 gives a tick every 4 cycles; third tick matches CMP=2.
        wr(A_PRESC, 32'd3);
        wr(A_CMP, 32'd2);
        wr(A_COUNT, 32'd0);
        wr(A_CTRL, 32'h7);
        repeat (3) @(negedge CLK);
        rd(A_COUNT, rv);
        check("auto_cnt_c3", rv, 32'd0);
        @(negedge CLK);
        rd(A_COUNT, rv);
        check("auto_cnt_c4", rv, 32'd1);
        repeat (4) @(negedge CLK);
        rd(A_COUNT, rv);
        check("auto_cnt_c8", rv, 32'd2);
        repeat (3) @(negedge CLK);
        check("auto_intr_c11", {31'h0, INTR}, 32'h0);
        @(negedge CLK);
        check("auto_intr_c12", {31'h0, INTR}, 32'h1);
        rd(A_COUNT, rv);
        check("auto_cnt_reload", rv, 32'd0);
        rd(A_STAT, rv);
        check("auto_pend", rv, 32'h1);
        wr(A_STAT, 32'h1);
        check("w1c_intr", {31'h0, INTR}, 32'h0);
        wr(A_CTRL, 32'h0);

        // One-shot: PRESC=0, CMP=5; sixth tick sets PEND and clears EN.
        wr(A_PRESC, 32'd0);
        wr(A_CMP, 32'd5);
        wr(A_COUNT, 32'd0);
        wr(A_CTRL, 32'h5);
        repeat (5) @(negedge CLK);
        rd(A_COUNT, rv);
        check("oneshot_cnt5", rv, 32'd5);
        check("oneshot_intr_pre", {31'h0, INTR}, 32'h0);
        @(negedge CLK);
        check("oneshot_intr", {31'h0, INTR}, 32'h1);
        rd(A_CTRL, rv);
        check("oneshot_en_off", rv, 32'h4);
        @(negedge CLK);
        rd(A_COUNT, rv);
        check("oneshot_cnt_hold", rv, 32'd5);
        wr(A_STAT, 32'h1);

        // Wrap 0xFFFF_FFFF -> 0, then match at 1 with IE off.
        wr(A_CMP, 32'd1);
        wr(A_COUNT, 32'hFFFF_FFFF);
        wr(A_CTRL, 32'h1);
        @(negedge CLK);
        rd(A_COUNT, rv);
        check("wrap_cnt0", rv, 32'd0);
        repeat (2) @(negedge CLK);
        rd(A_STAT, rv);
        check("wrap_pend", rv, 32'h1);
        check("wrap_intr_masked", {31'h0, INTR}, 32'h0);
        rd(A_CTRL, rv);
        check("wrap_en_off", rv, 32'h0);
        wr(A_STAT, 32'h0);
        rd(A_STAT, rv);
        check("stat_w0_noeffect", rv, 32'h1);
        wr(A_STAT, 32'h1);
        rd(A_STAT, rv);
        check("stat_w1c", rv, 32'h0);

        // Collision: W1C lands on the same edge PEND sets.
        wr(A_CMP, 32'd2);
        wr(A_COUNT, 32'd0);
        wr(A_CTRL, 32'h1);
        @(negedge CLK);
        wr(A_STAT, 32'h1);
        rd(A_STAT, rv);
        check("pend_beats_w1c", rv, 32'h1);
        wr(A_STAT, 32'h1);

        // Collision: COUNT write on a tick edge, then a COUNT write that restarts the prescaler.
        wr(A_PRESC, 32'd3);
        wr(A_CMP, 32'h0000_FFFF);
        wr(A_COUNT, 32'd0);
        wr(A_CTRL, 32'h3);
        repeat (2) @(negedge CLK);
        wr(A_COUNT, 32'h10);
        rd(A_COUNT, rv);
        check("cnt_wr_on_tick", rv, 32'h10);
        repeat (3) @(negedge CLK);
        rd(A_COUNT, rv);
        check("cnt_hold_c7", rv, 32'h10);
        @(negedge CLK);
        rd(A_COUNT, rv);
        check("cnt_tick_c8", rv, 32'h11);
        wr(A_COUNT, 32'h20);
        repeat (3) @(negedge CLK);
        rd(A_COUNT, rv);
        check("presc_cleared", rv, 32'h20);
        @(negedge CLK);
        rd(A_COUNT, rv);
        check("presc_restart_tick", rv, 32'h21);

        // Reset mid-count aborts the timer.
        IOBUS_ADDR = A_COUNT;
        #2 RESET = 1'b1;
        #1;
        check("reset2_iobus_in", IOBUS_IN, 32'h0);
        check("reset2_leds", {16'h0, LEDS}, 32'h0);
        @(negedge CLK);
        RESET = 1'b0;
        repeat (6) @(negedge CLK);
        rd(A_COUNT, rv);
        check("reset2_count", rv, 32'h0);
        rd(A_CTRL, rv);
        check("reset2_ctrl", rv, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
